// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch FIFO.
// Drives a 1-cycle-latency synchronous instruction memory, buffers {pc, instr}
// pairs and hands them to decode over valid/ready. A redirect flushes the
// queue, drops the return landing that cycle and restarts fetch at the target.
// Optional feature macro: FETCH_BYPASS_EN (a return into an empty queue is
// shown to decode in the same cycle it arrives).
module fetch_queue #(
  parameter int          PC_W     = 9,
  parameter int          INS_W    = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [PC_W-1:0]            id_pc,
  output logic [INS_W-1:0]           id_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  inflight_pc;
  logic             inflight;
  logic             kill;
  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [INS_W-1:0] ins_mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic          empty;
  logic          ret_ok;
  logic          bypass;
  logic          pop;
  logic          pop_fifo;
  logic          push;
  logic [CW:0]   demand;
  logic [CW:0]   limit;
  logic [PC_W-1:0] target;

  assign empty  = (count == '0);
  // A return is usable when a read was issued last cycle and it was not killed.
  assign ret_ok = inflight && !kill;

`ifdef FETCH_BYPASS_EN
  assign bypass = empty && ret_ok;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid  = !reset && (!empty || bypass);
  assign id_pc     = bypass ? inflight_pc : pc_mem[rd_ptr];
  assign id_instr  = bypass ? imem_rdata  : ins_mem[rd_ptr];
  assign occupancy = count;

  // Redirect cycles are flushes: nothing is consumed and nothing is written.
  assign pop      = id_valid && id_ready && !redirect_valid;
  assign pop_fifo = pop && !empty;
  assign push     = ret_ok && !redirect_valid && !(bypass && pop);

  // Reserve a slot for the read already in flight; a slot freed by this
  // cycle's pop can be reused by this cycle's request.
  assign demand   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign limit    = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
  assign imem_req = !reset && !redirect_valid && (demand < limit);

  assign imem_addr = fetch_pc & ~PC_W'(3);
  assign target    = redirect_pc & ~PC_W'(3);

  // Fetch PC, in-flight tracking, FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= PC_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      inflight <= imem_req;
      if (imem_req) inflight_pc <= imem_addr;
      if (redirect_valid) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Any read still outstanding past this edge belongs to the old path.
        // Issue is held off during a redirect, so only a request made in this
        // cycle could be outstanding.
        kill     <= imem_req;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + PC_W'(4);
        if (inflight) kill <= 1'b0;
        if (push) begin
          pc_mem[wr_ptr]  <= inflight_pc;
          ins_mem[wr_ptr] <= imem_rdata;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop_fifo) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop_fifo);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus a randomized phase. The reference
// model is the program-order stream: every instruction decode accepts must be
// the next sequential PC from the last reset/redirect target, carrying the
// memory word at that address.
module tb_fetch_queue;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int NW    = 1 << (PC_W-2);
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             id_valid;
  logic             id_ready;
  logic [PC_W-1:0]  id_pc;
  logic [INS_W-1:0] id_instr;
  logic [CW-1:0]    occupancy;

  logic [INS_W-1:0] mem [NW];
  logic [PC_W-1:0]  exp_pc;
  int passed = 0;
  int total  = 0;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, garbage when not requested.
  always @(posedge clk)
    imem_rdata <= imem_req ? mem[imem_addr[PC_W-1:2]] : $urandom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Apply inputs for one cycle and check the decode stream at the negedge.
  task automatic drive(input logic rst, input logic rv, input logic [PC_W-1:0] rpc,
                       input logic rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    @(negedge clk);
    chk("occ_bound", 64'(occupancy <= CW'(DEPTH)), 64'd1);
    if (imem_req) chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
    if (!rst && !rv && id_valid && id_ready) begin
      chk("stream_pc", 64'(id_pc), 64'(exp_pc));
      chk("stream_instr", 64'(id_instr), 64'(mem[exp_pc[PC_W-1:2]]));
      exp_pc = exp_pc + PC_W'(4);
    end
    if (rst)     exp_pc = '0;
    else if (rv) exp_pc = {rpc[PC_W-1:2], 2'b00};
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    exp_pc = '0;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;

    // Reset state.
    drive(1, 0, 0, 1); adv();
    drive(1, 0, 0, 1); adv();
    drive(1, 0, 0, 1);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_pc", 64'(id_pc), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    adv();

    // First request and first-valid latency.
    drive(0, 0, 0, 1);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", 64'(imem_addr), 64'd0);
    chk("first_valid0", 64'(id_valid), 64'd0);
    adv();
    drive(0, 0, 0, 1);
    chk("first_valid1", 64'(id_valid), 64'(BYP));
    adv();
    drive(0, 0, 0, 1);
    chk("first_valid2", 64'(id_valid), 64'd1);
    adv();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      chk("throughput", 64'(id_valid), 64'd1);
      adv();
    end

    // Stall fills the queue and stops requests.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (i == 9) begin
        chk("stall_occ", 64'(occupancy), 64'(DEPTH));
        chk("stall_req", 64'(imem_req), 64'd0);
      end
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      chk("drain_nogap", 64'(id_valid), 64'd1);
      adv();
    end

    // Redirect with 3 queued and a read in flight, coinciding with a pop.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (occupancy == CW'(3)) begin found = 1'b1; break; end
      drive(0, 0, 0, 0); adv();
    end
    chk("fill3", 64'(found), 64'd1);
    drive(0, 1, 9'h040, 1);
    chk("redir_noreq", 64'(imem_req), 64'd0);
    adv();
    drive(0, 0, 0, 1);
    chk("redir_occ", 64'(occupancy), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'h40);
    chk("redir_v1", 64'(id_valid), 64'd0);
    adv();
    drive(0, 0, 0, 1);
    chk("redir_v2", 64'(id_valid), 64'(BYP));
    adv();
    drive(0, 0, 0, 1);
    chk("redir_v3", 64'(id_valid), 64'd1);
    adv();

    // Address wrap at the top of the PC space (low target bits ignored).
    drive(0, 1, 9'h1FA, 1); adv();
    drive(0, 0, 0, 1); chk("wrap_a0", 64'(imem_addr), 64'h1F8); adv();
    drive(0, 0, 0, 1); chk("wrap_a1", 64'(imem_addr), 64'h1FC); adv();
    drive(0, 0, 0, 1); chk("wrap_a2", 64'(imem_addr), 64'h000); adv();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1); adv(); end

    // Reset with a full queue.
    for (int i = 0; i < 10; i++) begin drive(0, 0, 0, 0); adv(); end
    drive(0, 0, 0, 0);
    chk("full_occ", 64'(occupancy), 64'(DEPTH));
    adv();
    drive(1, 0, 0, 0); adv();
    drive(0, 0, 0, 1);
    chk("rst2_valid", 64'(id_valid), 64'd0);
    chk("rst2_occ", 64'(occupancy), 64'd0);
    chk("rst2_req", 64'(imem_req), 64'd1);
    chk("rst2_addr", 64'(imem_addr), 64'd0);
    adv();

    // Randomized stall and redirect traffic against the stream model.
    for (int i = 0; i < 400; i++) begin
      logic rv;
      rv = ($urandom_range(0, 11) == 0);
      drive(0, rv, PC_W'($urandom), ($urandom_range(0, 3) != 0));
      adv();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
